// File: rtl/apb3_master_bridge.sv
// apb3_master_bridge
// Converts single-beat valid/ready requests into APB3 SETUP/ACCESS transfers.
// It returns read data, error and timeout status on a valid/ready response port.
// Only one transfer is in flight at a time. A new request is accepted only in IDLE.
module apb3_master_bridge #(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 8,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                  PCLK,
  input  logic                  PRESETn,
  // request port
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  // response port
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_err,
  output logic                  rsp_timeout,
  // APB3 master port
  output logic [ADDR_WIDTH-1:0] PADDR,
  output logic                  PSEL,
  output logic                  PENABLE,
  output logic                  PWRITE,
  output logic [DATA_WIDTH-1:0] PWDATA,
  input  logic [DATA_WIDTH-1:0] PRDATA,
  input  logic                  PREADY,
  input  logic                  PSLVERR
);

  // The wait counter must be able to hold TIMEOUT_CYCLES itself, because it saturates there.
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT_CYCLES);
  // The counter value seen on the TIMEOUT_CYCLES-th ACCESS cycle. The first ACCESS cycle sees 0.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETUP  = 2'd1,
    S_ACCESS = 2'd2,
    S_RESP   = 2'd3
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_wait_cnt;

  logic w_accept;
  logic w_done;
  logic w_timeout;
  logic w_rsp_take;

  // req_ready comes straight from the state. It therefore reads 1 throughout reset.
  assign req_ready = (r_state == S_IDLE);

  assign w_accept = req_valid && req_ready;

  // The slave completes the ACCESS phase. PSLVERR only matters on this edge.
  assign w_done = (r_state == S_ACCESS) && PREADY;

  // The last permitted ACCESS cycle has PREADY still low. A ready on that same cycle takes priority.
  assign w_timeout = (r_state == S_ACCESS) && !PREADY && (r_wait_cnt == CNT_LAST);

  assign w_rsp_take = (r_state == S_RESP) && rsp_ready;

  // Next-state decode for the transfer sequencer.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_state_nxt = S_SETUP;
        end
      end
      S_SETUP: begin
        w_state_nxt = S_ACCESS;
      end
      S_ACCESS: begin
        if (w_done || w_timeout) begin
          w_state_nxt = S_RESP;
        end
      end
      S_RESP: begin
        if (w_rsp_take) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // State register. Reset drops any in-flight transfer.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Count ACCESS cycles that end without PREADY. The count is cleared in SETUP and never wraps.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      r_wait_cnt <= '0;
    end else if (r_state == S_SETUP) begin
      r_wait_cnt <= '0;
    end else if ((r_state == S_ACCESS) && !PREADY && (r_wait_cnt != CNT_MAX)) begin
      r_wait_cnt <= r_wait_cnt + 1'b1;
    end
  end

  // APB control outputs. Reset forces PSEL/PENABLE low immediately.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      PSEL    <= 1'b0;
      PENABLE <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          PSEL    <= w_accept;
          PENABLE <= 1'b0;
        end
        S_SETUP: begin
          PSEL    <= 1'b1;
          PENABLE <= 1'b1;
        end
        S_ACCESS: begin
          if (w_done || w_timeout) begin
            PSEL    <= 1'b0;
            PENABLE <= 1'b0;
          end
        end
        default: begin
          PSEL    <= 1'b0;
          PENABLE <= 1'b0;
        end
      endcase
    end
  end

  // Address, direction and write data are captured only at the accepting edge.
  // They are held unchanged until the next accept.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      PADDR  <= '0;
      PWRITE <= 1'b0;
      PWDATA <= '0;
    end else if (w_accept) begin
      PADDR  <= req_addr;
      PWRITE <= req_write;
      PWDATA <= req_write ? req_wdata : '0;
    end
  end

  // Response register: loaded when ACCESS ends and held until consumed.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      rsp_valid   <= 1'b0;
      rsp_rdata   <= '0;
      rsp_err     <= 1'b0;
      rsp_timeout <= 1'b0;
    end else if (w_done) begin
      rsp_valid   <= 1'b1;
      rsp_rdata   <= PWRITE ? '0 : PRDATA;
      rsp_err     <= PSLVERR;
      rsp_timeout <= 1'b0;
    end else if (w_timeout) begin
      rsp_valid   <= 1'b1;
      rsp_rdata   <= '0;
      rsp_err     <= 1'b1;
      rsp_timeout <= 1'b1;
    end else if (w_rsp_take) begin
      rsp_valid <= 1'b0;
    end
  end

endmodule
